// File: rtl/mem_lane_steer.sv
// mem_lane_steer
//   Registered issue-bundle steerer between decode and the execution threads.
//   Every load/store in a LANES-wide bundle is routed to the single
//   memory-capable output lane MEM_LANE. If a bundle holds several memory ops,
//   it is split over several output cycles, with one memory op per cycle. The
//   cycles after the first are residual cycles that carry only the memory op.
//
//   Lane layout (INS_W bits): {vld, des, s1, s2, op, ime, branch}, vld is the MSB.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     flush      synchronous flush of the held output and pending residuals
//     in_valid   input bundle valid
//     in_ready   input bundle accepted when in_valid & in_ready
//     in_ins     input bundle, lane k at [k*INS_W +: INS_W]
//     in_mem     per-lane load/store flag (ignored on lanes with vld=0)
//     out_valid  output bundle valid
//     out_ready  downstream accepts when out_valid & out_ready
//     out_ins    steered bundle, same layout as in_ins
//     out_split  1 = current output is a residual (memory-op-only) cycle
//     split_cnt  (STEER_STATS_EN only) saturating count of accepted bundles
//                holding more than one memory op
//
//   Configuration macro: STEER_STATS_EN adds the split_cnt port and counter.
module mem_lane_steer #(
    parameter int LANES    = 4,
    parameter int MEM_LANE = 3,
    parameter int DES_W    = 5,
    parameter int SRC_W    = 5,
    parameter int OP_W     = 6,
    parameter int IME_W    = 16,
    localparam int INS_W   = 1 + DES_W + 2*SRC_W + OP_W + IME_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*INS_W-1:0] in_ins,
    input  logic [LANES-1:0]       in_mem,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*INS_W-1:0] out_ins,
    output logic                   out_split
`ifdef STEER_STATS_EN
    ,
    output logic [15:0]            split_cnt
`endif
);

    localparam int unsigned MEM_LANE_U = MEM_LANE;
    localparam int unsigned LANES_U    = LANES;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        SPLIT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LANES-1:0]       pending;
    logic [LANES*INS_W-1:0] held;

    logic [LANES-1:0]       mem_vec;
    logic [LANES-1:0]       first_oh;
    logic                   multi;
    logic [INS_W-1:0]       mem_lane_ins;
    logic [LANES*INS_W-1:0] first_ins;
    logic [LANES-1:0]       next_oh;
    logic [LANES-1:0]       rest;
    logic [LANES*INS_W-1:0] res_ins;
    logic                   accept;
    logic                   out_hs;

    // Isolates the lowest set bit of a lane mask.
    function automatic logic [LANES-1:0] lowest_bit(input logic [LANES-1:0] m);
        return m & (~m + LANES'(1));
    endfunction

    // Selects the lane addressed by a one-hot mask (all zero if none is set).
    function automatic logic [INS_W-1:0] pick(input logic [LANES*INS_W-1:0] b,
                                              input logic [LANES-1:0]       oh);
        logic [INS_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < LANES_U; k++) begin
            if (oh[k]) begin
                r = r | b[k*INS_W +: INS_W];
            end
        end
        return r;
    endfunction

    // First output of an incoming bundle.
    always_comb begin
        mem_vec = '0;
        for (int unsigned k = 0; k < LANES_U; k++) begin
            mem_vec[k] = in_mem[k] & in_ins[k*INS_W + INS_W - 1];
        end
        first_oh     = lowest_bit(mem_vec);
        multi        = |(mem_vec & ~first_oh);
        mem_lane_ins = in_ins[MEM_LANE*INS_W +: INS_W];
        first_ins    = in_ins;
        if (|mem_vec) begin
            for (int unsigned k = 0; k < LANES_U; k++) begin
                if (k == MEM_LANE_U) begin
                    first_ins[k*INS_W +: INS_W] = pick(in_ins, first_oh);
                end else if (first_oh[k] && !mem_vec[MEM_LANE]) begin
                    // A non-memory instruction displaced from MEM_LANE takes
                    // the slot freed by the issued memory op.
                    first_ins[k*INS_W +: INS_W] = mem_lane_ins;
                end else if (mem_vec[k]) begin
                    // Deferred memory op: emit an empty lane for now.
                    first_ins[k*INS_W +: INS_W] = '0;
                end
            end
        end
    end

    // Residual output: the next pending memory op alone on MEM_LANE.
    always_comb begin
        next_oh = lowest_bit(pending);
        rest    = pending & ~next_oh;
        res_ins = '0;
        res_ins[MEM_LANE*INS_W +: INS_W] = pick(held, next_oh);
    end

    // Next-state and handshake outputs.
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = !flush && (state != SPLIT) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = multi ? SPLIT : HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        state_nxt = multi ? SPLIT : HOLD;
                    end else if (out_hs) begin
                        state_nxt = EMPTY;
                    end
                end
                SPLIT: begin
                    if (out_hs) begin
                        state_nxt = (|rest) ? SPLIT : HOLD;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ins   <= '0;
            out_split <= 1'b0;
            pending   <= '0;
            held      <= '0;
        end else if (flush) begin
            out_split <= 1'b0;
            pending   <= '0;
        end else if (accept) begin
            out_ins   <= first_ins;
            out_split <= 1'b0;
            pending   <= mem_vec & ~first_oh;
            held      <= in_ins;
        end else if (state == SPLIT && out_hs) begin
            out_ins   <= res_ins;
            out_split <= 1'b1;
            pending   <= rest;
        end
    end

`ifdef STEER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (accept && multi && split_cnt != '1) begin
            split_cnt <= split_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_lane_steer.sv
module tb_mem_lane_steer;

    localparam int LANES = 4;
    localparam int ML    = 3;
    localparam int INS_W = 1 + 5 + 2*5 + 6 + 16 + 1;
    localparam int BW    = LANES * INS_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_ins = '0;
    logic [LANES-1:0] in_mem = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_ins;
    logic          out_split;
`ifdef STEER_STATS_EN
    logic [15:0]   split_cnt;
`endif

    mem_lane_steer #(.LANES(LANES), .MEM_LANE(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ins    (in_ins),
        .in_mem    (in_mem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_split (out_split)
`ifdef STEER_STATS_EN
        ,
        .split_cnt (split_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of the output beats still owed downstream.
    // care[k]=0 means only "lane k has vld=0" is required.
    typedef struct packed {
        logic [BW-1:0]    ins;
        logic [LANES-1:0] care;
        logic             split;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_split_cnt = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    function automatic logic [INS_W-1:0] mk_lane(input bit vld);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[INS_W-1] = vld;
        return r[INS_W-1:0];
    endfunction

    function automatic logic [BW-1:0] mk_bundle();
        logic [BW-1:0] b;
        for (int k = 0; k < LANES; k++) b[k*INS_W +: INS_W] = mk_lane(1'b1);
        return b;
    endfunction

    function automatic logic [INS_W-1:0] ln(input logic [BW-1:0] b, input int k);
        return b[k*INS_W +: INS_W];
    endfunction

    function automatic bit bundle_ok(input exp_t e, input logic [BW-1:0] act);
        for (int k = 0; k < LANES; k++) begin
            if (e.care[k]) begin
                if (act[k*INS_W +: INS_W] !== e.ins[k*INS_W +: INS_W]) return 1'b0;
            end else if (act[k*INS_W + INS_W - 1] !== 1'b0) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Model of acceptance: no residuals owed, and the output slot is free or draining.
    function automatic bit exp_in_ready();
        return !flush && (exp_q.size() <= 1) && (exp_q.size() == 0 || out_ready);
    endfunction

    task automatic model_accept(input logic [BW-1:0] ins, input logic [LANES-1:0] mem);
        logic [INS_W-1:0] lanes [LANES];
        int   ops[$];
        bit   ml_is_mem;
        exp_t e;
        ml_is_mem = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lanes[k] = ins[k*INS_W +: INS_W];
            if (mem[k] && lanes[k][INS_W-1]) begin
                ops.push_back(k);
                if (k == ML) ml_is_mem = 1'b1;
            end
        end
        e.ins   = ins;
        e.care  = '1;
        e.split = 1'b0;
        if (ops.size() > 0) begin
            foreach (ops[i]) if (ops[i] != ML) e.care[ops[i]] = 1'b0;
            e.ins[ML*INS_W +: INS_W] = lanes[ops[0]];
            if (!ml_is_mem) begin
                e.ins[ops[0]*INS_W +: INS_W] = lanes[ML];
                e.care[ops[0]] = 1'b1;
            end
        end
        exp_q.push_back(e);
        for (int i = 1; i < ops.size(); i++) begin
            e.ins   = '0;
            e.care  = '0;
            e.care[ML] = 1'b1;
            e.ins[ML*INS_W +: INS_W] = lanes[ops[i]];
            e.split = 1'b1;
            exp_q.push_back(e);
        end
        if (ops.size() > 1) exp_split_cnt++;
    endtask

    task automatic drive(input bit v, input logic [BW-1:0] ins, input logic [LANES-1:0] mem,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_ins    = ins;
        in_mem    = mem;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Advance the model by the cycle just driven, then move to the next negedge.
    task automatic tick();
        bit acc, hs;
        acc = in_valid && exp_in_ready();
        hs  = (exp_q.size() > 0) && out_ready;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (hs) void'(exp_q.pop_front());
            if (acc) model_accept(in_ins, in_mem);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_split !== 1'b0 || out_ins !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: out_valid=%b out_split=%b out_ins=%h, required 0/0/0",
                     out_valid, out_split, out_ins);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
        exp_q.delete();
        exp_split_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_single_mem();
        logic [BW-1:0] b;
        b = mk_bundle();
        drive(1'b1, b, 4'b0001, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_split !== 1'b0 || ln(out_ins, 0) !== ln(b, 3) ||
            ln(out_ins, 1) !== ln(b, 1) || ln(out_ins, 2) !== ln(b, 2) || ln(out_ins, 3) !== ln(b, 0)) begin
            miscompares++;
            $display("FAIL single_mem_swap: valid=%b split=%b out=%h, required lanes {3,1,2,0} of %h",
                     out_valid, out_split, out_ins, b);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_mem_drain: out_valid=%b, required 0", out_valid);
        end
        tick();
    endtask

    task automatic test_two_mem();
        logic [BW-1:0] b;
        b = mk_bundle();
        drive(1'b1, b, 4'b0101, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_split !== 1'b0 || in_ready !== 1'b0 ||
            ln(out_ins, 3) !== ln(b, 0) || ln(out_ins, 0) !== ln(b, 3) ||
            ln(out_ins, 1) !== ln(b, 1) || out_ins[2*INS_W + INS_W - 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL two_mem_first: valid=%b split=%b in_ready=%b out=%h in=%h",
                     out_valid, out_split, in_ready, out_ins, b);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_split !== 1'b1 || in_ready !== 1'b1 || ln(out_ins, 3) !== ln(b, 2) ||
            out_ins[INS_W-1] !== 1'b0 || out_ins[2*INS_W-1] !== 1'b0 || out_ins[3*INS_W-1] !== 1'b0) begin
            miscompares++;
            $display("FAIL two_mem_residual: valid=%b split=%b in_ready=%b out=%h, required lane3=%h alone",
                     out_valid, out_split, in_ready, out_ins, ln(b, 2));
        end
        tick();
    endtask

    task automatic test_stall_split();
        logic [BW-1:0] b;
        logic [BW-1:0] snap;
        b = mk_bundle();
        drive(1'b1, b, 4'b1110, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        snap = out_ins;
        vectors++;
        if (out_valid !== 1'b1 || ln(out_ins, 3) !== ln(b, 1) || ln(out_ins, 0) !== ln(b, 0) ||
            out_ins[2*INS_W-1] !== 1'b0 || out_ins[3*INS_W-1] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_first: valid=%b out=%h in=%h", out_valid, out_ins, b);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_ins !== snap || out_split !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d out=%h split=%b, required %h split 0", c, out_ins, out_split, snap);
            end
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || ln(out_ins, 3) !== ln(b, i) || out_split !== (i != 1)) begin
                miscompares++;
                $display("FAIL stall_issue: op %0d lane3=%h split=%b, required %h split %b",
                         i, ln(out_ins, 3), out_split, ln(b, i), (i != 1));
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_empty: out_valid=%b, required 0", out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] bb [10];
        for (int i = 0; i < 10; i++) begin
            bb[i] = mk_bundle();
            drive(1'b1, bb[i], 4'b0000, 1'b1, 1'b0);
            vectors++;
            if (in_ready !== 1'b1 || (i > 0 && (out_valid !== 1'b1 || out_ins !== bb[i-1]))) begin
                miscompares++;
                $display("FAIL back_to_back: beat %0d in_ready=%b valid=%b out=%h", i, in_ready, out_valid, out_ins);
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_ins !== bb[9] || out_split !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_last: valid=%b out=%h, required %h", out_valid, out_ins, bb[9]);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [BW-1:0] b;
        b = mk_bundle();
        drive(1'b1, b, 4'b0111, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk_bundle(), 4'b0000, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b0 || ln(out_ins, 3) !== ln(b, 0) || ln(out_ins, 0) !== ln(b, 3)) begin
            miscompares++;
            $display("FAIL flush_setup: in_ready=%b out=%h in=%h", in_ready, out_ins, b);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_clear: cycle %0d out_valid=%b in_ready=%b, required 0/1", c, out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [BW-1:0]    b;
        logic [LANES-1:0] m;
        bit               all_inv;
        for (int c = 0; c < 800; c++) begin
            all_inv = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < LANES; k++)
                b[k*INS_W +: INS_W] = mk_lane(!all_inv && ($urandom_range(0, 9) != 0));
            m = LANES'($urandom);
            drive($urandom_range(0, 3) != 0, b, m, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            vectors++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== exp_in_ready() ||
                (exp_q.size() > 0 && (out_split !== exp_q[0].split || !bundle_ok(exp_q[0], out_ins)))) begin
                miscompares++;
                $display("FAIL random: cycle %0d valid=%b in_ready=%b split=%b out=%h, required valid=%b in_ready=%b %s",
                         c, out_valid, in_ready, out_split, out_ins, (exp_q.size() > 0), exp_in_ready(),
                         (exp_q.size() > 0) ? $sformatf("split=%b lanes=%h care=%b", exp_q[0].split, exp_q[0].ins, exp_q[0].care) : "");
            end
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== (exp_q.size() > 0) ||
                (exp_q.size() > 0 && (out_split !== exp_q[0].split || !bundle_ok(exp_q[0], out_ins)))) begin
                miscompares++;
                $display("FAIL random_drain: cycle %0d valid=%b split=%b out=%h", c, out_valid, out_split, out_ins);
            end
            tick();
        end
`ifdef STEER_STATS_EN
        vectors++;
        if (split_cnt !== 16'(exp_split_cnt)) begin
            miscompares++;
            $display("FAIL split_cnt: split_cnt=%0d, required %0d", split_cnt, exp_split_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [BW-1:0] b;
        b = mk_bundle();
        drive(1'b1, b, 4'b1111, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || ln(out_ins, 3) !== ln(b, 0) || out_ins[INS_W-1] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_setup: valid=%b out=%h in=%h", out_valid, out_ins, b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_split !== 1'b0 || out_ins !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b split=%b out=%h, required all 0", out_valid, out_split, out_ins);
        end
`ifdef STEER_STATS_EN
        vectors++;
        if (split_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset_cnt: split_cnt=%0d, required 0", split_cnt);
        end
`endif
        exp_q.delete();
        exp_split_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL async_no_reissue: cycle %0d valid=%b in_ready=%b, required 0/1", c, out_valid, in_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_mem();
        test_two_mem();
        test_stall_split();
        test_back_to_back();
        test_flush();
`ifdef STEER_STATS_EN
        vectors++;
        if (split_cnt !== 16'(exp_split_cnt)) begin
            miscompares++;
            $display("FAIL split_cnt_directed: split_cnt=%0d, required %0d", split_cnt, exp_split_cnt);
        end
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
